hex_scan_display: RTL

- Parametrised successor to the single-digit hex-to-seven-segment decoder.
- Drives N_DIGITS multiplexed common-anode seven-segment digits from one shared segment bus, using a time-division scan.
- Adds frame-synchronous tear-free value loading, leading-zero blanking and per-digit blink.
- Sits between the datapath (value producer) and the board display pins.

---
 rtl/hex_scan_display.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/hex_scan_display.sv
// Multiplexed N-digit hex seven-segment driver: scans common-anode digits over one shared
// segment bus, loads new values only on frame boundaries, blanks leading zeros and blinks digits.
module hex_scan_display #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [N_DIGITS-1:0]     blink_en,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    pending,
    output logic                    frame_tick
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int NSEL = 2 ** IW;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]           presc_reg;
    logic [IW-1:0]           idx_reg;
    logic [FW-1:0]           frame_cnt_reg;
    logic                    phase_reg;
    logic [4*N_DIGITS-1:0]   disp_reg;
    logic [4*N_DIGITS-1:0]   stage_reg;

    logic                    slot_end;
    logic                    frame_end;
    logic                    zero_run;
    logic [N_DIGITS-1:0]     lz_mask;
    logic [N_DIGITS-1:0]     an_next;
    logic [3:0]              nib_sel [NSEL];
    logic [NSEL-1:0]         blank_sel;
    logic [3:0]              cur_nib;
    logic                    cur_blank;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    assign slot_end  = (presc_reg == PRESC_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);

    // A digit is a leading zero when it and every more-significant digit is zero.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run   = zero_run && (disp_reg[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_run && (k != 0);
        end
    end

    // Select tables padded to a power of two so the digit index never runs off the end.
    generate
        for (genvar gi = 0; gi < NSEL; gi++) begin : g_sel
            if (gi < N_DIGITS) begin : g_real
                assign nib_sel[gi]   = disp_reg[4*gi +: 4];
                assign blank_sel[gi] = (blank_lz && lz_mask[gi]) || (phase_reg && blink_en[gi]);
                assign an_next[gi]   = (idx_reg != IW'(gi));
            end else begin : g_pad
                assign nib_sel[gi]   = 4'h0;
                assign blank_sel[gi] = 1'b1;
            end
        end
    endgenerate

    assign cur_nib   = nib_sel[idx_reg];
    assign cur_blank = blank_sel[idx_reg];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            presc_reg     <= '0;
            idx_reg       <= '0;
            frame_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            disp_reg      <= '0;
            stage_reg     <= '0;
            pending       <= 1'b0;
            frame_tick    <= 1'b0;
            seg           <= 7'h7F;
            an            <= '1;
        end else begin
            presc_reg <= slot_end ? '0 : presc_reg + PW'(1);
            if (slot_end) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
            end
            frame_tick <= frame_end;

            if (load) begin
                stage_reg <= value;
            end
            // Display only changes between frames, so a frame never shows mixed values.
            if (frame_end) begin
                pending <= 1'b0;
                if (load) begin
                    disp_reg <= value;
                end else if (pending) begin
                    disp_reg <= stage_reg;
                end
                if (frame_cnt_reg == FRAME_LAST) begin
                    frame_cnt_reg <= '0;
                    phase_reg     <= ~phase_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + FW'(1);
                end
            end else if (load) begin
                pending <= 1'b1;
            end

            // First cycle of each slot is dark to hide segment changes.
            an  <= (presc_reg == '0) ? '1 : an_next;
            seg <= cur_blank ? 7'h7F : glyph(cur_nib);
        end
    end

endmodule
